uart_frame_decoder: RTL

Downstream consumer of the dual-lane 9600-baud UART receiver. It takes each received byte pair (primary lane plus weighting lane) on the receiver's done strobe and assembles length-prefixed, checksummed command frames into a local buffer. Completed frames are presented to the control logic through a valid/ack handshake, with an error strobe for malformed or stalled frames.

---
 rtl/uart_frame_decoder_pkg.sv | 33 +++
 rtl/uart_byte_event.sv | 63 ++++++
 rtl/uart_frame_decoder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_decoder_pkg
//  Description : Shared types and constants for the UART command-frame
//                decoder: FSM state encoding, error codes and the default
//                start-of-frame byte.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_frame_decoder_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // err_code values reported alongside the err strobe
    localparam logic [1:0] ERR_LEN = 2'd0;  // length field zero or too large
    localparam logic [1:0] ERR_SUM = 2'd1;  // checksum byte did not match
    localparam logic [1:0] ERR_TMO = 2'd2;  // receiver went quiet mid-frame
    localparam logic [1:0] ERR_OVR = 2'd3;  // byte arrived while a frame was held

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // A length byte is usable when it is non-zero and fits the buffer.
    function automatic logic len_ok(input logic [7:0] len_byte, input int max_len);
        return (len_byte != 8'd0) && (int'(len_byte) <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_event.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_event
//  Description : Brings the receiver's byte_done level into the clk domain
//                through a two-flop synchronizer and turns each rising edge
//                into a single-cycle ev pulse. Both byte lanes are captured
//                on the detected edge so they are valid during ev.
//  Ports       : clk, rst_n          clock / async active-low reset
//                byte_done           receiver done level (asynchronous)
//                byte_in, byte_aux_in primary / weighting lane bytes
//                ev                  one-cycle byte event
//                ev_byte, ev_aux     lane copies, valid while ev is high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_event (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_done,
    input  logic [7:0] byte_in,
    input  logic [7:0] byte_aux_in,
    output logic       ev,
    output logic [7:0] ev_byte,
    output logic [7:0] ev_aux
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;
    logic r_ev;
    logic [7:0] r_byte;
    logic [7:0] r_aux;
    logic w_rise;

    assign w_rise = r_sync2 & ~r_sync2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_ev      <= 1'b0;
            r_byte    <= 8'd0;
            r_aux     <= 8'd0;
        end else begin
            r_sync1   <= byte_done;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_ev      <= w_rise;
            // The lanes are stable while byte_done is high, which covers the
            // synchronizer delay, so sampling them on the edge is safe.
            if (w_rise) begin
                r_byte <= byte_in;
                r_aux  <= byte_aux_in;
            end
        end
    end

    assign ev      = r_ev;
    assign ev_byte = r_byte;
    assign ev_aux  = r_aux;

endmodule
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_decoder
//  Description : Assembles HEADER / length / payload / checksum frames from
//                the dual-lane UART receiver into a local buffer and presents
//                completed frames through a valid/ack handshake.
//  Ports       : clk, rst_n            clock / async active-low reset
//                byte_in, byte_aux_in   receiver lanes
//                byte_done              receiver done level
//                frame_valid, frame_ack held-frame handshake
//                frame_len              payload length of the held frame
//                rd_addr, rd_data       payload read port (1-cycle latency)
//                err, err_code          error strobe and sticky error code
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER,
    parameter int         TIMEOUT_CLKS = 250000,
    localparam int        LENW         = $clog2(MAX_LEN + 1),
    localparam int        AW           = $clog2(MAX_LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      byte_in,
    input  logic [7:0]      byte_aux_in,
    input  logic            byte_done,
    output logic            frame_valid,
    input  logic            frame_ack,
    output logic [LENW-1:0] frame_len,
    input  logic [AW-1:0]   rd_addr,
    output logic [15:0]     rd_data,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam int          TW         = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT_CLKS - 1);

    logic            w_ev;
    logic [7:0]      w_ev_byte;
    logic [7:0]      w_ev_aux;

    state_t          r_state,       w_state_nxt;
    logic [LENW-1:0] r_len,         w_len_nxt;
    logic [7:0]      r_sum,         w_sum_nxt;
    logic [LENW-1:0] r_idx,         w_idx_nxt;
    logic            r_frame_valid, w_valid_nxt;
    logic [LENW-1:0] r_frame_len,   w_frame_len_nxt;
    logic            r_err,         w_err_nxt;
    logic [1:0]      r_err_code,    w_err_code_nxt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [15:0]     r_rd_data;
    logic [15:0]     r_buf [MAX_LEN];

    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic            w_tmo_active;
    logic            w_tmo_hit;

    uart_byte_event u_byte_event (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_done   (byte_done),
        .byte_in     (byte_in),
        .byte_aux_in (byte_aux_in),
        .ev          (w_ev),
        .ev_byte     (w_ev_byte),
        .ev_aux      (w_ev_aux)
    );

    // Only a partially received frame can time out; idle hunting and a held
    // frame wait indefinitely.
    assign w_tmo_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                          (r_state == ST_CHECK);
    assign w_tmo_hit    = w_tmo_active && !w_ev && (r_tmo_cnt == c_tmo_last);
    assign w_wr_addr    = r_idx[AW-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_sum_nxt       = r_sum;
        w_idx_nxt       = r_idx;
        w_valid_nxt     = r_frame_valid;
        w_frame_len_nxt = r_frame_len;
        w_err_nxt       = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_wr_en         = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (w_ev && (w_ev_byte == HEADER)) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_ev) begin
                    if (len_ok(w_ev_byte, MAX_LEN)) begin
                        w_len_nxt   = LENW'(w_ev_byte);
                        // The length byte is part of the checksum.
                        w_sum_nxt   = w_ev_byte;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_LEN;
                        w_state_nxt    = ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_ev) begin
                    w_wr_en   = 1'b1;
                    w_sum_nxt = r_sum + w_ev_byte;
                    w_idx_nxt = r_idx + LENW'(1);
                    if (r_idx == r_len - LENW'(1)) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_ev) begin
                    if (w_ev_byte == r_sum) begin
                        w_valid_nxt     = 1'b1;
                        w_frame_len_nxt = r_len;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_SUM;
                        w_state_nxt    = ST_HUNT;
                    end
                end
            end
            ST_HOLD: begin
                // Ack takes priority: a byte landing in the release cycle is
                // dropped quietly because the frame is being given up anyway.
                if (frame_ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_HUNT;
                end else if (w_ev) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = ERR_OVR;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase

        // Never coincides with a byte event, so it cannot collide with the
        // per-state error decisions above.
        if (w_tmo_hit) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_TMO;
            w_state_nxt    = ST_HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_len         <= '0;
            r_sum         <= 8'd0;
            r_idx         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
            r_err         <= 1'b0;
            r_err_code    <= 2'd0;
            r_tmo_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_sum         <= w_sum_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_valid <= w_valid_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_err         <= w_err_nxt;
            r_err_code    <= w_err_code_nxt;
            r_tmo_cnt     <= (w_ev || !w_tmo_active) ? '0 : r_tmo_cnt + TW'(1);
        end
    end

    // Payload storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= {w_ev_aux, w_ev_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 16'd0;
        end else begin
            r_rd_data <= r_buf[rd_addr];
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_len   = r_frame_len;
    assign rd_data     = r_rd_data;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire
